// File: rtl/pc_unit_param.sv
// pc_unit_param: parametrised fetch-stage program counter.
// Priority next-PC selection (trap > PC_Execute+Imm > Reg1+Imm > sequential),
// valid/ready handshake toward instruction fetch, one-cycle redirect pulse and
// a saturating redirect counter.
// Optional build macro PC_MISALIGN_CHECK_EN: jump/branch targets with bit1 set
// are diverted to the trap vector and flagged on misalign.
module pc_unit_param #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              STEP         = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic [1:0]       pc_sel,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  pc_execute,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  reg1,
    input  logic [XLEN-1:0]  trap_vec,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             redirect_taken,
    output logic [CNT_W-1:0] redirect_count,
    output logic             misalign
);

    localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) return v;
        return v + CNT_W'(1);
    endfunction

    logic            advance;
    logic            is_jump;
    logic            redirect;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] jump_dest;
    logic [XLEN-1:0] pc_next;

    assign advance   = pc_valid & fetch_ready & ~stall;
    assign is_jump   = (pc_sel == 2'b01) || (pc_sel == 2'b10);
    assign redirect  = trap_req | is_jump;
    assign trap_base = {trap_vec[XLEN-1:2], 2'b00};
    assign jalr_sum  = reg1 + imm;

    // Branch/jump target; register-indirect jumps drop bit0.
    assign jump_target = (pc_sel == 2'b01) ? (pc_execute + imm)
                                           : {jalr_sum[XLEN-1:1], 1'b0};

`ifdef PC_MISALIGN_CHECK_EN
    logic mis_hit;
    logic misalign_q;

    // Only branch/jump targets are checked; the trap path is trusted.
    assign mis_hit   = ~trap_req & is_jump & jump_target[1];
    assign jump_dest = mis_hit ? trap_base : jump_target;

    // One-cycle misalign pulse aligned with the diverted pc.
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= mis_hit;
    end

    assign misalign = misalign_q;
`else
    assign jump_dest = jump_target;
    assign misalign  = 1'b0;
`endif

    // Next-PC priority: trap, then jumps, then sequential advance, else hold.
    always_comb begin
        pc_next = pc;
        if (trap_req)     pc_next = trap_base;
        else if (is_jump) pc_next = jump_dest;
        else if (advance) pc_next = pc + STEP_X;
    end

    // PC state, handshake valid, redirect pulse and counter; reset wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_VECTOR;
            pc_valid       <= 1'b0;
            redirect_taken <= 1'b0;
            redirect_count <= '0;
        end else begin
            pc             <= pc_next;
            pc_valid       <= 1'b1;
            redirect_taken <= redirect;
            if (redirect) redirect_count <= sat_inc(redirect_count);
        end
    end

endmodule

// File: tb/tb_pc_unit_param.sv
// tb_pc_unit_param: directed vectors with hand-computed expectations pushed
// into a scoreboard queue; a negedge monitor pops and compares DUT outputs.
module tb_pc_unit_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b1;
    logic [1:0]  pc_sel = 2'b00;
    logic        trap_req = 1'b0;
    logic [31:0] pc_execute = '0;
    logic [31:0] imm = '0;
    logic [31:0] reg1 = '0;
    logic [31:0] trap_vec = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        redirect_taken;
    logic [1:0]  redirect_count;
    logic        misalign;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        rt;
        logic [1:0]  cnt;
        logic        mis;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_unit_param #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0100), .STEP(4), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .pc_sel(pc_sel), .trap_req(trap_req), .pc_execute(pc_execute),
        .imm(imm), .reg1(reg1), .trap_vec(trap_vec), .pc(pc),
        .pc_valid(pc_valid), .redirect_taken(redirect_taken),
        .redirect_count(redirect_count), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare all outputs.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "pc", pc, e.pc);
            chk(e.tag, "pc_valid", 32'(pc_valid), 32'(e.vld));
            chk(e.tag, "redirect_taken", 32'(redirect_taken), 32'(e.rt));
            chk(e.tag, "redirect_count", 32'(redirect_count), 32'(e.cnt));
            chk(e.tag, "misalign", 32'(misalign), 32'(e.mis));
        end
    end

    // Drive one cycle of inputs, then queue the state expected after the edge.
    task automatic vec(input string tag, input logic r, input logic s,
                       input logic f, input logic [1:0] sel, input logic t,
                       input logic [31:0] pce, input logic [31:0] im,
                       input logic [31:0] r1, input logic [31:0] tv,
                       input logic [31:0] epc, input logic ev, input logic ert,
                       input logic [1:0] ec, input logic em);
        exp_t e;
        rst = r; stall = s; fetch_ready = f; pc_sel = sel; trap_req = t;
        pc_execute = pce; imm = im; reg1 = r1; trap_vec = tv;
        e.pc = epc; e.vld = ev; e.rt = ert; e.cnt = ec; e.mis = em; e.tag = tag;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    // Idle cycle: no redirect, given stall/fetch_ready.
    task automatic idle(input string tag, input logic s, input logic f,
                        input logic [31:0] epc, input logic [1:0] ec);
        vec(tag, 1'b0, s, f, 2'b00, 1'b0, 0, 0, 0, 0, epc, 1'b1, 1'b0, ec, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        vec(tag, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 0, 0, 0, 32'h100, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        // Reset and bubble, then sequential fetch
        do_reset("reset0");
        do_reset("reset1");
        idle("bubble", 1'b0, 1'b1, 32'h100, 2'd0);
        idle("seq104", 1'b0, 1'b1, 32'h104, 2'd0);
        idle("seq108", 1'b0, 1'b1, 32'h108, 2'd0);

        // Handshake hold via fetch_ready=0, then via stall=1
        vec("jmp200", 0, 0, 1, 2'b01, 0, 32'h200, 32'h0, 0, 0, 32'h200, 1, 1, 2'd1, 0);
        for (int i = 0; i < 3; i++) idle("hold_nr", 1'b0, 1'b0, 32'h200, 2'd1);
        idle("adv204", 1'b0, 1'b1, 32'h204, 2'd1);
        for (int i = 0; i < 3; i++) idle("hold_st", 1'b1, 1'b1, 32'h204, 2'd1);
        idle("adv208", 1'b0, 1'b1, 32'h208, 2'd1);

        // PC_Execute+Imm redirect under stall, negative offset
        do_reset("reset2");
        idle("bubble2", 1'b0, 1'b1, 32'h100, 2'd0);
        vec("br2f0", 0, 1, 1, 2'b01, 0, 32'h300, 32'hFFFF_FFF0, 0, 0, 32'h2F0, 1, 1, 2'd1, 0);
        idle("br_hold", 1'b1, 1'b1, 32'h2F0, 2'd1);
        idle("br_adv", 1'b0, 1'b1, 32'h2F4, 2'd1);

        // JALR bit0 clear, then trap wins over JALR in the same cycle
        vec("jalr", 0, 0, 1, 2'b10, 0, 0, 32'h4, 32'h401, 0, 32'h404, 1, 1, 2'd2, 0);
        vec("trap", 0, 0, 1, 2'b10, 1, 0, 32'h4, 32'h401, 32'h807, 32'h804, 1, 1, 2'd3, 0);
        idle("post_trap", 1'b0, 1'b1, 32'h808, 2'd3);

        // Counter saturation at 3 with CNT_W=2
        do_reset("reset3");
        idle("bubble3", 1'b0, 1'b1, 32'h100, 2'd0);
        vec("sat1", 0, 0, 1, 2'b01, 0, 32'h10, 0, 0, 0, 32'h10, 1, 1, 2'd1, 0);
        vec("sat2", 0, 0, 1, 2'b01, 0, 32'h10, 0, 0, 0, 32'h10, 1, 1, 2'd2, 0);
        vec("sat3", 0, 0, 1, 2'b01, 0, 32'h10, 0, 0, 0, 32'h10, 1, 1, 2'd3, 0);
        vec("sat4", 0, 0, 1, 2'b01, 0, 32'h10, 0, 0, 0, 32'h10, 1, 1, 2'd3, 0);
        vec("sat5", 0, 0, 1, 2'b01, 0, 32'h10, 0, 0, 0, 32'h10, 1, 1, 2'd3, 0);
        idle("sat_idle", 1'b0, 1'b1, 32'h14, 2'd3);

        // Address wrap on sequential advance
        vec("to_top", 0, 0, 1, 2'b01, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 1, 1, 2'd3, 0);
        idle("wrap", 1'b0, 1'b1, 32'h0, 2'd3);

        // Reset coinciding with a redirect discards it
        vec("rst_jmp", 1, 0, 1, 2'b01, 1, 32'h500, 32'h4, 0, 32'h900, 32'h100, 0, 0, 2'd0, 0);
        idle("bubble4", 1'b0, 1'b1, 32'h100, 2'd0);

        // pc_sel=11 behaves as sequential
        vec("sel11", 0, 0, 1, 2'b11, 0, 32'h700, 32'h4, 0, 0, 32'h104, 1, 0, 2'd0, 0);
        vec("sel11_h", 0, 0, 0, 2'b11, 0, 32'h700, 32'h4, 0, 0, 32'h104, 1, 0, 2'd0, 0);

        // Redirect during the post-reset bubble
        do_reset("reset5");
        vec("bub_jmp", 0, 0, 1, 2'b01, 0, 32'h40, 0, 0, 0, 32'h40, 1, 1, 2'd1, 0);
        idle("bub_adv", 1'b0, 1'b1, 32'h44, 2'd1);

        // Trap ignores stall and fetch_ready
        vec("trap_st", 0, 1, 0, 2'b00, 1, 0, 0, 0, 32'h203, 32'h200, 1, 1, 2'd2, 0);

        // Misaligned branch target
`ifdef PC_MISALIGN_CHECK_EN
        vec("misal", 0, 0, 1, 2'b01, 0, 32'h1000, 32'h2, 0, 32'h80, 32'h80, 1, 1, 2'd3, 1);
        idle("misal_nx", 1'b0, 1'b1, 32'h84, 2'd3);
`else
        vec("misal", 0, 0, 1, 2'b01, 0, 32'h1000, 32'h2, 0, 32'h80, 32'h1002, 1, 1, 2'd3, 0);
        idle("misal_nx", 1'b0, 1'b1, 32'h1006, 2'd3);
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
